audio_pll_lock_ctrl: RTL and testbench

- Reset/lock sequencer for the audio PLL (50 MHz refclk to 18.432 MHz codec clock).
- Drives the PLL reset and watches its `locked` output (synchronised into the refclk domain).
- Qualifies lock with a stability window, then releases the downstream audio-domain reset request.
- On lock loss or software request, re-sequences the PLL. After repeated lock timeouts, parks in a fault state.

---
 rtl/audio_clk_pkg.sv | 17 +
 rtl/audio_sync_bit.sv | 28 ++
 rtl/audio_pll_lock_ctrl.sv | 130 +++++++++++++
 tb/tb_audio_pll_lock_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_clk_pkg.sv
// Shared types and widths for the audio clock domain: PLL sequencer states and counter sizes.
package audio_clk_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_state_e;

    // 20 bits covers the 10 ms lock timeout at 50 MHz (500000 cycles)
    localparam int CNT_W   = 20;
    localparam int RETRY_W = 4;
    localparam int LOST_W  = 8;

endpackage

// File: rtl/audio_sync_bit.sv
// Single-bit multi-flop synchroniser, reset to 0. Also used for audio_rst_req into outclk.
module audio_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/audio_pll_lock_ctrl.sv
// Audio PLL reset/lock sequencer: pulses PLL reset, qualifies lock over a stability window,
// releases the audio-domain reset, retries on timeout and parks in FAULT after MAX_RETRIES.
module audio_pll_lock_ctrl
    import audio_clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 50,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                audio_rst_req,
    output logic                ready,
    output logic                fault,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [LOST_W-1:0]   lock_lost_cnt
);

    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MAX_R    = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic [LOST_W-1:0]  lost_q, lost_d;
    logic               pll_rst_q, pll_rst_d;
    logic               audio_rst_q, audio_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    audio_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        lost_d    = lost_q;
        retry_inc = retry_q + RETRY_W'(1);

        unique case (state_q)
            RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == MAX_R) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STB_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    if (lost_q != '1) lost_d = lost_q + LOST_W'(1);
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = RESET_PLL;
        endcase

        // Software relock wins over everything but still lets a concurrent lock drop be counted
        if (relock_req) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end

        if (state_d != state_q || relock_req) begin
            cnt_d = '0;
        end else if (state_q == RUN || state_q == FAULT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
        audio_rst_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            audio_rst_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            audio_rst_q <= audio_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign audio_rst_req = audio_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_audio_pll_lock_ctrl.sv
// Scoreboard bench for audio_pll_lock_ctrl: each expected output change (cycle, value) is queued
// by the stimulus; the monitor pops one entry whenever the output vector changes.
module tb_audio_pll_lock_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, audio_rst_req, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    typedef struct packed {
        int          cyc;
        logic [15:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          fails = 0;
    int          lost = 0;
    logic [15:0] prev = '0;

    audio_pll_lock_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .SYNC_STAGES         (2)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .audio_rst_req (audio_rst_req),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    function automatic logic [15:0] vec(input bit p, input bit a, input bit r, input bit f,
                                        input int rt, input int l);
        logic [3:0] rt4;
        logic [7:0] l8;
        rt4 = rt[3:0];
        l8  = l[7:0];
        return {p, a, r, f, rt4, l8};
    endfunction

    task automatic push(input int c, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) @(negedge refclk);
    endtask

    function automatic int sat(input int l);
        return (l >= 255) ? 255 : l + 1;
    endfunction

    // Monitor: outputs are sampled mid-cycle, after the edge numbered cyc
    always @(negedge refclk) begin
        logic [15:0] cur;
        exp_t        e;
        cur = {pll_rst, audio_rst_req, ready, fault, retry_cnt, lock_lost_cnt};
        if (cur !== prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    fails++;
                    $display("FAIL out_change got cyc=%0d val=%h, want cyc=%0d val=%h",
                             cyc, cur, e.cyc, e.v);
                end
            end
            prev = cur;
        end
    end

    // One lock-drop pulse in RUN; optionally a relock_req lands on the edge the FSM sees the drop
    task automatic drop_pulse(input bit with_relock);
        int c;
        int l2;
        c  = cyc;
        l2 = sat(lost);
        push(c + 3,  vec(1, 1, 0, 0, 0, l2));
        push(c + 7,  vec(0, 1, 0, 0, 0, l2));
        push(c + 16, vec(0, 0, 1, 0, 0, l2));
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        if (with_relock) begin
            tick(1);
            relock_req = 1'b1;
            tick(1);
            relock_req = 1'b0;
        end
        lost = l2;
        tick_to(c + 18);
    endtask

    initial begin
        int c;
        int l2;

        // reset values appear on the first edge
        push(1, vec(1, 1, 0, 0, 0, 0));
        tick(2);

        // 1: no lock -> two timeouts -> FAULT
        c = cyc;
        push(c + 4,  vec(0, 1, 0, 0, 0, 0));
        push(c + 36, vec(1, 1, 0, 0, 1, 0));
        push(c + 40, vec(0, 1, 0, 0, 1, 0));
        push(c + 72, vec(1, 1, 0, 1, 2, 0));
        rst = 1'b0;
        tick_to(c + 80);

        // 5a: relock from FAULT with lock present
        c = cyc;
        push(c + 1,  vec(1, 1, 0, 0, 0, 0));
        push(c + 5,  vec(0, 1, 0, 0, 0, 0));
        push(c + 14, vec(0, 0, 1, 0, 0, 0));
        pll_locked = 1'b1;
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        tick_to(c + 16);

        // 4: single drop in RUN; 5b: drop coinciding with relock_req
        drop_pulse(1'b0);
        drop_pulse(1'b1);

        // 2: one timeout, then lock arrives 5 cycles into WAIT_LOCK; ready 10 edges after sampling
        c  = cyc;
        l2 = sat(lost);
        push(c + 3,  vec(1, 1, 0, 0, 0, l2));
        push(c + 7,  vec(0, 1, 0, 0, 0, l2));
        push(c + 39, vec(1, 1, 0, 0, 1, l2));
        push(c + 43, vec(0, 1, 0, 0, 1, l2));
        push(c + 59, vec(0, 0, 1, 0, 0, l2));
        pll_locked = 1'b0;
        tick_to(c + 48);
        pll_locked = 1'b1;
        lost = l2;
        tick_to(c + 62);

        // 3: glitch during STABLE sends FSM back to WAIT_LOCK; retry_cnt holds at 1
        c  = cyc;
        l2 = sat(lost);
        push(c + 3,  vec(1, 1, 0, 0, 0, l2));
        push(c + 7,  vec(0, 1, 0, 0, 0, l2));
        push(c + 39, vec(1, 1, 0, 0, 1, l2));
        push(c + 43, vec(0, 1, 0, 0, 1, l2));
        push(c + 62, vec(0, 0, 1, 0, 0, l2));
        pll_locked = 1'b0;
        tick_to(c + 43);
        pll_locked = 1'b1;
        tick_to(c + 50);
        pll_locked = 1'b0;
        tick_to(c + 51);
        pll_locked = 1'b1;
        lost = l2;
        tick_to(c + 65);

        // 4: repeated drops saturate lock_lost_cnt
        for (int i = 0; i < 300; i++) drop_pulse(1'b0);

        // 6: rst while in STABLE clears everything, then sequencing restarts
        c  = cyc;
        l2 = sat(lost);
        push(c + 3,  vec(1, 1, 0, 0, 0, l2));
        push(c + 7,  vec(0, 1, 0, 0, 0, l2));
        push(c + 11, vec(1, 1, 0, 0, 0, 0));
        push(c + 15, vec(0, 1, 0, 0, 0, 0));
        push(c + 24, vec(0, 0, 1, 0, 0, 0));
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick_to(c + 10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lost = 0;
        tick_to(c + 27);

        tick(5);
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_expectations got=%0d want=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
